sum_cla_pipe: RTL and testbench

//   Parametrised, pipelined carry-lookahead adder/subtractor for mantissa/exponent datapaths.

---
 rtl/sum_cla_pipe.sv | 157 +++++++++++++++
 tb/tb_sum_cla_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit CLA groups.
// Each stage resolves one chunk of GRP_PER_STAGE groups; the chunk carry and any unresolved operand bits are registered between stages.
module sum_cla_pipe #(
  parameter int unsigned WIDTH         = 24,
  parameter int unsigned GRP_PER_STAGE = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam int unsigned CW   = 4 * GRP_PER_STAGE;
  localparam int unsigned NSTG = WIDTH / CW;

  // One chunk: per-bit and per-group generate/propagate lookahead. Returns {cout, sum}.
  function automatic logic [CW:0] cla_chunk(input logic [CW-1:0] a,
                                            input logic [CW-1:0] b,
                                            input logic          cin);
    logic [CW-1:0] g;
    logic [CW-1:0] p;
    logic [CW:0]   c;
    logic          gg;
    logic          pg;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    gg   = 1'b0;
    pg   = 1'b0;
    for (int j = 0; j < int'(GRP_PER_STAGE); j++) begin
      int n;
      n      = 4 * j;
      c[n+1] = g[n] | (p[n] & c[n]);
      c[n+2] = g[n+1] | (p[n+1] & g[n]) | (p[n+1] & p[n] & c[n]);
      c[n+3] = g[n+2] | (p[n+2] & g[n+1]) | (p[n+2] & p[n+1] & g[n])
             | (p[n+2] & p[n+1] & p[n] & c[n]);
      gg     = g[n+3] | (p[n+3] & g[n+2]) | (p[n+3] & p[n+2] & g[n+1])
             | (p[n+3] & p[n+2] & p[n+1] & g[n]);
      pg     = p[n+3] & p[n+2] & p[n+1] & p[n];
      c[n+4] = gg | (pg & c[n]);
    end
    return {c[CW], p ^ c[CW-1:0]};
  endfunction

  logic [NSTG-1:0] v;
  logic [NSTG-1:0] acc;

  // A stage can take new data when it is empty or its contents move on this cycle.
  always_comb begin
    logic nxt;
    acc = '0;
    nxt = ~v[NSTG-1] | i_ready;
    acc[NSTG-1] = nxt;
    for (int k = int'(NSTG) - 2; k >= 0; k--) begin
      nxt    = ~v[k] | nxt;
      acc[k] = nxt;
    end
  end

  assign o_ready = acc[0];

  for (genvar k = 0; k < int'(NSTG); k++) begin : g_stg
    localparam int unsigned IN_REM = WIDTH - CW * k;
    localparam int unsigned DONE   = CW * (k + 1);

    logic [IN_REM-1:0] a_in;
    logic [IN_REM-1:0] b_in;
    logic              c_in;
    logic              up_v;
    logic [CW:0]       res;
    logic [DONE-1:0]   s_next;
    logic [DONE-1:0]   s_q;
    logic              c_q;
    logic              v_q;

    if (k == 0) begin : g_first
      assign a_in   = i_a;
      assign b_in   = i_sub ? ~i_b : i_b;
      assign c_in   = i_sub | i_cin;
      assign up_v   = i_valid;
      assign s_next = res[CW-1:0];
    end else begin : g_next
      assign a_in   = g_stg[k-1].g_rem.a_q;
      assign b_in   = g_stg[k-1].g_rem.b_q;
      assign c_in   = g_stg[k-1].c_q;
      assign up_v   = v[k-1];
      assign s_next = {res[CW-1:0], g_stg[k-1].s_q};
    end

    assign res  = cla_chunk(a_in[CW-1:0], b_in[CW-1:0], c_in);
    assign v[k] = v_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (acc[k]) begin
        v_q <= up_v;
        if (up_v) begin
          s_q <= s_next;
          c_q <= res[CW];
        end
      end
    end

    // Operand bits not yet resolved travel alongside the carry.
    if (k < int'(NSTG) - 1) begin : g_rem
      logic [IN_REM-CW-1:0] a_q;
      logic [IN_REM-CW-1:0] b_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (acc[k] && up_v) begin
          a_q <= a_in[IN_REM-1:CW];
          b_q <= b_in[IN_REM-1:CW];
        end
      end
    end

    // Final stage also registers the flags so no output depends on o_sum combinationally.
    if (k == int'(NSTG) - 1) begin : g_last
      logic c_msb;
      logic ovf_q;
      logic zero_q;
      assign c_msb = a_in[CW-1] ^ b_in[CW-1] ^ res[CW-1];
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (acc[k] && up_v) begin
          ovf_q  <= res[CW] ^ c_msb;
          zero_q <= ~|s_next;
        end
      end
    end
  end

  assign o_valid = v[NSTG-1];
  assign o_sum   = g_stg[NSTG-1].s_q;
  assign o_cout  = g_stg[NSTG-1].c_q;
  assign o_ovf   = g_stg[NSTG-1].g_last.ovf_q;
  assign o_zero  = g_stg[NSTG-1].g_last.zero_q;

endmodule

// File: tb/tb_sum_cla_pipe.sv
// Self-checking bench for sum_cla_pipe: arithmetic reference model with an in-order scoreboard plus literal vectors.
module tb_sum_cla_pipe;

  localparam int unsigned WIDTH = 24;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } res_t;

  logic             i_clk   = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [WIDTH-1:0] i_a     = '0;
  logic [WIDTH-1:0] i_b     = '0;
  logic             i_sub   = 1'b0;
  logic             i_cin   = 1'b0;
  logic             o_valid;
  logic             i_ready = 1'b1;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;
  logic             o_zero;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   emit_cnt = 0;
  res_t q[$];
  res_t exp_r;
  res_t out_prev;
  logic stall_prev = 1'b0;

  sum_cla_pipe #(.WIDTH(WIDTH), .GRP_PER_STAGE(2)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_sub  (i_sub),
    .i_cin  (i_cin),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sum  (o_sum),
    .o_cout (o_cout),
    .o_ovf  (o_ovf),
    .o_zero (o_zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub, input logic cin);
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   t;
    res_t             r;
    bx     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, (sub | cin)};
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    r.ovf  = (a[WIDTH-1] == bx[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  // Scoreboard: handshake conditions seen at negedge are the ones the next posedge acts on.
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(o_valid), 64'(1'b1));
        chk("hold_data", 64'({o_sum, o_cout, o_ovf, o_zero}), 64'(out_prev));
      end
      if (o_valid && i_ready) begin
        chk("emit_has_expected", 64'(q.size() > 0), 64'(1'b1));
        if (q.size() > 0) begin
          exp_r = q.pop_front();
          chk("sum",  64'(o_sum),  64'(exp_r.sum));
          chk("cout", 64'(o_cout), 64'(exp_r.cout));
          chk("ovf",  64'(o_ovf),  64'(exp_r.ovf));
          chk("zero", 64'(o_zero), 64'(exp_r.zero));
        end
        emit_cnt++;
      end
      if (i_valid && o_ready) q.push_back(model(i_a, i_b, i_sub, i_cin));
      stall_prev = o_valid && !i_ready;
      out_prev   = {o_sum, o_cout, o_ovf, o_zero};
    end
  end

  // Presents an op and returns once it is accepted at the next rising edge.
  task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic cin, output int waits);
    @(posedge i_clk);
    #1;
    i_a = a; i_b = b; i_sub = sub; i_cin = cin; i_valid = 1'b1;
    waits = 0;
    while (1) begin
      @(negedge i_clk);
      waits++;
      if (o_ready) break;
      if (waits > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL drive_timeout: o_ready stayed 0 for %0d cycles, required 1", waits);
        break;
      end
    end
  endtask

  task automatic lit(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic sub, input logic cin, input logic [WIDTH-1:0] e_sum,
                     input logic e_cout, input logic e_ovf, input logic e_zero);
    int w;
    int lat;
    drive_op(a, b, sub, cin, w);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge i_clk);
      lat++;
      if (o_valid || lat > 20) break;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(3));
    chk({nm, "_sum"},  64'(o_sum),  64'(e_sum));
    chk({nm, "_cout"}, 64'(o_cout), 64'(e_cout));
    chk({nm, "_ovf"},  64'(o_ovf),  64'(e_ovf));
    chk({nm, "_zero"}, 64'(o_zero), 64'(e_zero));
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    chk({nm, "_drained"}, 64'(q.size()), 64'(0));
  endtask

  initial begin
    int w;
    int tot;
    int n_acc;
    int e0;

    @(negedge i_clk);
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_sum",   64'(o_sum),   64'(0));
    chk("rst_flags", 64'({o_cout, o_ovf, o_zero}), 64'(0));
    chk("rst_ready", 64'(o_ready), 64'(1));
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    lit("wrap",      24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1);
    lit("sub_neg",   24'h000005, 24'h000007, 1'b1, 1'b0, 24'hFFFFFE, 1'b0, 1'b0, 1'b0);
    lit("sub_pos",   24'h000007, 24'h000005, 1'b1, 1'b0, 24'h000002, 1'b1, 1'b0, 1'b0);
    lit("sub_cin",   24'h000007, 24'h000005, 1'b1, 1'b1, 24'h000002, 1'b1, 1'b0, 1'b0);
    lit("sovf",      24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1, 1'b0);
    lit("add_cin",   24'h00000F, 24'h000010, 1'b0, 1'b1, 24'h000020, 1'b0, 1'b0, 1'b0);
    lit("stg_carry", 24'h00FFFF, 24'h000001, 1'b0, 1'b0, 24'h010000, 1'b0, 1'b0, 1'b0);
    lit("sub_eq",    24'h123456, 24'h123456, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b1);
    lit("neg_ovf",   24'h800000, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b1);

    // Full-rate stream: every op must be taken on its first cycle.
    tot = 0;
    for (int i = 0; i < 100; i++) begin
      drive_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), w);
      tot += w;
    end
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    chk("stream_cycles", 64'(tot), 64'(100));
    drain("stream");

    // Backpressure: three ops fill the pipe, then input stalls.
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    i_a = WIDTH'($urandom); i_b = WIDTH'($urandom); i_sub = 1'($urandom); i_cin = 1'($urandom);
    i_valid = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_ready) n_acc++;
      @(posedge i_clk);
      #1;
      if (o_ready) begin
        i_a = WIDTH'($urandom); i_b = WIDTH'($urandom); i_sub = 1'($urandom); i_cin = 1'($urandom);
      end
    end
    @(negedge i_clk);
    chk("stall_accepts", 64'(n_acc), 64'(3));
    chk("stall_ready",   64'(o_ready), 64'(0));
    chk("stall_valid",   64'(o_valid), 64'(1));
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    e0 = emit_cnt;
    repeat (3) @(negedge i_clk);
    @(posedge i_clk);
    #1 chk("release_b2b", 64'(emit_cnt - e0), 64'(3));
    for (int i = 0; i < 10; i++)
      drive_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), w);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    drain("release");

    // Reset with the pipe full: in-flight ops are discarded.
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      drive_op(24'h000100 + 24'(i), 24'h000001, 1'b0, 1'b0, w);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'(0));
    chk("midrst_sum",   64'(o_sum),   64'(0));
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    e0 = emit_cnt;
    repeat (10) @(negedge i_clk);
    @(posedge i_clk);
    #1;
    chk("midrst_no_stale", 64'(emit_cnt - e0), 64'(0));
    chk("midrst_idle",     64'(o_valid), 64'(0));
    chk("midrst_q_empty",  64'(q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
